mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output handshake and two modes: single-shot select and automatic channel scan. It generalises the team's fixed 8:1 single-bit dataflow mux into a clocked block that feeds a downstream consumer (display driver, serialiser or logger) one selected sample at a time. In scan mode it sweeps all channels in order without per-sample select control.

## Interface
- `WIDTH`, 8: bits per channel.
- `NCH`, 8: channel count, ≥ 1.
- `SELW`, `$clog2(NCH)` (minimum 1): select/channel index width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `d`  in  `[NCH-1:0][WIDTH-1:0]`  channel inputs; sampled only at capture edges.
- `sel`  in  SELW  channel for single-shot mode.
- `mode`  in  1  0 = single, 1 = scan; sampled with `start`.
- `start`  in  1  begin an operation; ignored unless idle.
- `abort`  in  1  cancel the operation in progress.
- `out_ready`  in  1  consumer accepts `y`.
- `out_valid`  out  1  `y`/`y_ch` hold a valid sample.
- `y`  out  WIDTH  selected sample.
- `y_ch`  out  SELW  channel index of `y`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when an operation completes normally.
- `err`  out  1  one-cycle pulse on an out-of-range `sel`.

## Operation
- States: IDLE, HOLD (single sample pending), SCAN.
- A handshake occurs on any edge where `out_valid && out_ready`.
- IDLE, `start && !mode`:
  - `sel < NCH`: `y <= d[sel]`, `y_ch <= sel`, `out_valid <= 1`, go to HOLD.
  - `sel ≥ NCH`: `y <= 0`, `y_ch <= sel`, `out_valid <= 1`, `err` pulses, go to HOLD.
- IDLE, `start && mode`: `y <= d[0]`, `y_ch <= 0`, `out_valid <= 1`, go to SCAN. `sel` is ignored.
- HOLD: on handshake, `out_valid <= 0`, `done` pulses, go to IDLE.
- SCAN, on handshake:
  - `y_ch == NCH-1`: `out_valid <= 0`, `done` pulses, go to IDLE.
  - Otherwise: `y_ch <= y_ch+1`, `y <= d[y_ch+1]` sampled at that edge, `out_valid` stays 1.
- While `out_valid && !out_ready`, `y` and `y_ch` stay stable; input changes are not reflected.
- `abort` in HOLD/SCAN: `out_valid <= 0`, go to IDLE, no `done`.
  - `abort` with a simultaneous handshake: the handshake counts as delivered; no further samples are produced.
- `abort` in IDLE, and `start` in HOLD/SCAN: no effect.
- `start` and `abort` together in IDLE: `start` wins.
- `NCH == 1`: scan emits exactly one sample, then `done`.

## Timing
- Reset values (asynchronous): state IDLE, `out_valid=0`, `y=0`, `y_ch=0`, `busy=0`, `done=0`, `err=0`.
- Reset mid-operation discards the pending sample immediately.
- Latency: `start` at edge k gives `out_valid=1` after edge k.
- Throughput in SCAN: one sample per cycle while `out_ready` is held high. A full scan with `out_ready=1` takes NCH cycles from the first valid cycle to `done`.
- `done` and `err` are registered, one cycle wide. `done` is asserted in the cycle after the final handshake edge.
- `busy` is a registered decode of state. It goes low in the same cycle `done` is high.
- No combinational path from `out_ready` to `out_valid` or `y`.

## Structure
- Package `mux_pkg`:
  - `state_t` enum {IDLE, HOLD, SCAN}.
  - `mode_t` enum {MODE_SINGLE=0, MODE_SCAN=1}.
- Sub-module `mux_n`: purely combinational WIDTH-bit NCH:1 mux.
  - Outputs 0 for an out-of-range index and provides an in-range flag.
  - `mux_scan` instantiates one `mux_n`, indexed by `sel`, 0, or `y_ch+1` according to state and event.

## Test plan
- Single shot, NCH=8, WIDTH=8, `d[i]=8'h10+i`, `sel=5`, `out_ready=1` → `y=8'h15`, `y_ch=5`, one valid cycle, `done` the next cycle.
- Scan with `out_ready=1` → `y` = 10,11,…,17 on consecutive cycles, `y_ch` = 0…7, `done` once, `busy` low afterwards.
- Scan with `out_ready` toggled 1,0,0,1,… → no sample skipped or duplicated; `y` stable during stalls; `d[2]` changed mid-stall appears only when captured.
- NCH=6, SELW=3, single shot with `sel=7` → `y=0`, `err` pulses once, then handshake and `done`.
- Scan with `abort` on the third handshake edge → exactly 3 samples delivered, no `done`, IDLE; a `start` in the next cycle is accepted.
- `reset` asserted asynchronously mid-scan with `out_valid=1` → all outputs 0 immediately; no output until a new `start`.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types for the registered N:1 sample multiplexer.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

endpackage

// File: rtl/mux_scan_if.sv
// Control, channel data and valid/ready output bundle for mux_scan.
interface mux_scan_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) ();
  logic [NCH-1:0][WIDTH-1:0] d;
  logic [SELW-1:0]           sel;
  logic                      mode;
  logic                      start;
  logic                      abort;
  logic                      out_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          y;
  logic [SELW-1:0]           y_ch;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    output d, sel, mode, start, abort, out_ready,
    input  out_valid, y, y_ch, busy, done, err
  );

  modport slave (
    input  d, sel, mode, start, abort, out_ready,
    output out_valid, y, y_ch, busy, done, err
  );
endinterface

// File: rtl/mux_n.sv
// Combinational WIDTH-bit NCH:1 mux; zero output and in_range low for an index >= NCH.
module mux_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0][WIDTH-1:0] d,
  input  logic [SELW-1:0]           idx,
  output logic [WIDTH-1:0]          y,
  output logic                      in_range
);
  always_comb begin
    y        = '0;
    in_range = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (idx == SELW'(i)) begin
        y        = d[i];
        in_range = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with single-shot and sequential-scan modes feeding a
// valid/ready consumer one sample at a time.
module mux_scan
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input logic         clk,
  input logic         reset,
  mux_scan_if.slave   bus
);
  state_t           state;
  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic [SELW-1:0]  y_ch_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [SELW-1:0]  idx;
  logic [WIDTH-1:0] mux_y;
  logic             mux_ok;
  logic             hs;
  logic             last_ch;

  assign hs      = out_valid_q && bus.out_ready;
  assign last_ch = (y_ch_q == SELW'(NCH - 1));

  // One shared mux: start picks sel (or channel 0 in scan), scan advance picks y_ch+1.
  always_comb begin
    idx = y_ch_q + SELW'(1);
    if (state == IDLE) begin
      idx = (mode_t'(bus.mode) == MODE_SCAN) ? '0 : bus.sel;
    end
  end

  mux_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) u_mux (
    .d        (bus.d),
    .idx      (idx),
    .y        (mux_y),
    .in_range (mux_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_ch_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            y_q         <= mux_y;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            if (mode_t'(bus.mode) == MODE_SCAN) begin
              y_ch_q <= '0;
              state  <= SCAN;
            end else begin
              y_ch_q <= bus.sel;
              err_q  <= !mux_ok;
              state  <= HOLD;
            end
          end
        end
        HOLD, SCAN: begin
          // Abort overrides completion: a coincident handshake is delivered but no done.
          if (bus.abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else if (hs) begin
            if (state == HOLD || last_ch) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state       <= IDLE;
            end else begin
              y_ch_q <= y_ch_q + SELW'(1);
              y_q    <= mux_y;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_ch      = y_ch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: NCH=8, NCH=6 (out-of-range select) and NCH=1 instances.
module tb_mux_scan;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  mux_scan_if #(.WIDTH(8), .NCH(8), .SELW(3)) b8 ();
  mux_scan_if #(.WIDTH(8), .NCH(6), .SELW(3)) b6 ();
  mux_scan_if #(.WIDTH(8), .NCH(1), .SELW(1)) b1 ();

  mux_scan #(.WIDTH(8), .NCH(8), .SELW(3)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));
  mux_scan #(.WIDTH(8), .NCH(6), .SELW(3)) u6 (.clk(clk), .reset(reset), .bus(b6.slave));
  mux_scan #(.WIDTH(8), .NCH(1), .SELW(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    b8.d = '0; b8.sel = '0; b8.mode = 1'b0; b8.start = 1'b0; b8.abort = 1'b0; b8.out_ready = 1'b0;
    b6.d = '0; b6.sel = '0; b6.mode = 1'b0; b6.start = 1'b0; b6.abort = 1'b0; b6.out_ready = 1'b0;
    b1.d = '0; b1.sel = '0; b1.mode = 1'b0; b1.start = 1'b0; b1.abort = 1'b0; b1.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_all();
    step();
    step();
    total++;
    if ({b8.out_valid, b8.busy, b8.done, b8.err, b8.y, b8.y_ch} !== 15'h0)
      $display("FAIL reset_b8: got %h expected 0", {b8.out_valid, b8.busy, b8.done, b8.err, b8.y, b8.y_ch});
    else passed++;
    total++;
    if ({b6.out_valid, b6.busy, b1.out_valid, b1.busy} !== 4'h0)
      $display("FAIL reset_b6_b1: got %b expected 0000", {b6.out_valid, b6.busy, b1.out_valid, b1.busy});
    else passed++;
    #2 reset = 1'b0;
    step();
  endtask

  // Single-shot: sample must equal d[sel] at the start edge and hold through stalls.
  task automatic test_single;
    logic [7:0] dv [8];
    int s, stall;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) dv[i] = (r == 0) ? 8'(8'h10 + i) : 8'($urandom);
      s     = (r == 0) ? 5 : int'($urandom_range(7));
      stall = (r == 0) ? 0 : int'($urandom_range(3));
      for (int i = 0; i < 8; i++) b8.d[i] = dv[i];
      b8.sel = 3'(s); b8.mode = 1'b0; b8.start = 1'b1; b8.out_ready = (stall == 0);
      step();
      b8.start = 1'b0;
      total++;
      if ({b8.out_valid, b8.busy, b8.err, b8.done, b8.y_ch, b8.y} !== {4'b1100, 3'(s), dv[s]})
        $display("FAIL single_capture: got %h expected %h",
                 {b8.out_valid, b8.busy, b8.err, b8.done, b8.y_ch, b8.y}, {4'b1100, 3'(s), dv[s]});
      else passed++;
      for (int c = 0; c < stall; c++) begin
        for (int i = 0; i < 8; i++) b8.d[i] = 8'($urandom);
        step();
        total++;
        if ({b8.out_valid, b8.y_ch, b8.y} !== {1'b1, 3'(s), dv[s]})
          $display("FAIL single_stall: got %h expected %h", {b8.out_valid, b8.y_ch, b8.y}, {1'b1, 3'(s), dv[s]});
        else passed++;
      end
      b8.out_ready = 1'b1;
      step();
      total++;
      if ({b8.out_valid, b8.busy, b8.err, b8.done} !== 4'b0001)
        $display("FAIL single_done: got %b expected 0001", {b8.out_valid, b8.busy, b8.err, b8.done});
      else passed++;
      b8.out_ready = 1'b0;
      step();
      total++;
      if ({b8.out_valid, b8.done} !== 2'b00)
        $display("FAIL single_done_pulse: got %b expected 00", {b8.out_valid, b8.done});
      else passed++;
    end
  endtask

  // Scan: the model tracks which channel is owed next and the value latched for it.
  // rmode 0 = ready held high, 1 = pattern 1,0,0,1, 2 = random ready with d churn.
  task automatic test_scan(input int rmode);
    int         k;
    logic [7:0] cap;
    bit         active, rdy;
    int         pat [4] = '{1, 0, 0, 1};
    for (int i = 0; i < 8; i++) b8.d[i] = (rmode == 0) ? 8'(8'h10 + i) : 8'($urandom);
    b8.mode = 1'b1; b8.sel = 3'($urandom_range(7)); b8.start = 1'b1; b8.out_ready = 1'b0;
    k = 0; cap = b8.d[0]; active = 1'b1;
    step();
    b8.start = 1'b0;
    for (int cyc = 0; cyc < 100 && active; cyc++) begin
      total++;
      if ({b8.out_valid, b8.busy, b8.done, b8.y_ch, b8.y} !== {3'b110, 3'(k), cap})
        $display("FAIL scan_sample m%0d c%0d: got %h expected %h", rmode, cyc,
                 {b8.out_valid, b8.busy, b8.done, b8.y_ch, b8.y}, {3'b110, 3'(k), cap});
      else passed++;
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (pat[cyc % 4] != 0) : 1'($urandom_range(1));
      if (rmode != 0) begin
        b8.d[2] = 8'($urandom);
        if (rmode == 2) for (int i = 0; i < 8; i++) b8.d[i] = 8'($urandom);
      end
      b8.out_ready = rdy;
      if (rdy) begin
        if (k == 7) active = 1'b0;
        else begin
          k++;
          cap = b8.d[k];
        end
      end
      step();
    end
    total++;
    if (active) $display("FAIL scan_timeout m%0d: got unfinished expected done", rmode);
    else if ({b8.out_valid, b8.busy, b8.done} !== 3'b001)
      $display("FAIL scan_done m%0d: got %b expected 001", rmode, {b8.out_valid, b8.busy, b8.done});
    else passed++;
    b8.out_ready = 1'b0;
    step();
    total++;
    if ({b8.out_valid, b8.busy, b8.done} !== 3'b000)
      $display("FAIL scan_after m%0d: got %b expected 000", rmode, {b8.out_valid, b8.busy, b8.done});
    else passed++;
  endtask

  task automatic test_abort;
    logic [7:0] dv [8];
    for (int i = 0; i < 8; i++) begin dv[i] = 8'($urandom); b8.d[i] = dv[i]; end
    b8.mode = 1'b1; b8.start = 1'b1; b8.out_ready = 1'b1;
    step();
    b8.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({b8.out_valid, b8.y_ch, b8.y} !== {1'b1, 3'(c), dv[c]})
        $display("FAIL abort_sample%0d: got %h expected %h", c, {b8.out_valid, b8.y_ch, b8.y}, {1'b1, 3'(c), dv[c]});
      else passed++;
      if (c == 2) b8.abort = 1'b1;
      step();
    end
    b8.abort = 1'b0;
    total++;
    if ({b8.out_valid, b8.busy, b8.done} !== 3'b000)
      $display("FAIL abort_idle: got %b expected 000", {b8.out_valid, b8.busy, b8.done});
    else passed++;
    // Restart immediately after abort, with abort also high: start wins in IDLE.
    b8.mode = 1'b0; b8.sel = 3'd4; b8.start = 1'b1; b8.abort = 1'b1; b8.out_ready = 1'b0;
    step();
    b8.start = 1'b0; b8.abort = 1'b0;
    total++;
    if ({b8.out_valid, b8.busy, b8.done, b8.y_ch, b8.y} !== {3'b110, 3'd4, dv[4]})
      $display("FAIL abort_restart: got %h expected %h", {b8.out_valid, b8.busy, b8.done, b8.y_ch, b8.y},
               {3'b110, 3'd4, dv[4]});
    else passed++;
    // start while HOLD must be ignored.
    b8.mode = 1'b1; b8.sel = 3'd1; b8.start = 1'b1;
    step();
    b8.start = 1'b0;
    total++;
    if ({b8.out_valid, b8.y_ch, b8.y} !== {1'b1, 3'd4, dv[4]})
      $display("FAIL hold_start_ignored: got %h expected %h", {b8.out_valid, b8.y_ch, b8.y}, {1'b1, 3'd4, dv[4]});
    else passed++;
    b8.abort = 1'b1;
    step();
    b8.abort = 1'b0;
    total++;
    if ({b8.out_valid, b8.busy, b8.done} !== 3'b000)
      $display("FAIL hold_abort: got %b expected 000", {b8.out_valid, b8.busy, b8.done});
    else passed++;
    b8.abort = 1'b1;
    step();
    b8.abort = 1'b0;
    total++;
    if ({b8.out_valid, b8.busy, b8.done} !== 3'b000)
      $display("FAIL idle_abort: got %b expected 000", {b8.out_valid, b8.busy, b8.done});
    else passed++;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 8; i++) b8.d[i] = 8'($urandom);
    b8.mode = 1'b1; b8.start = 1'b1; b8.out_ready = 1'b0;
    step();
    b8.start = 1'b0;
    step();
    total++;
    if (b8.out_valid !== 1'b1) $display("FAIL areset_pre: got %b expected 1", b8.out_valid);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({b8.out_valid, b8.busy, b8.done, b8.err, b8.y, b8.y_ch} !== 15'h0)
      $display("FAIL areset_immediate: got %h expected 0", {b8.out_valid, b8.busy, b8.done, b8.err, b8.y, b8.y_ch});
    else passed++;
    #2 reset = 1'b0;
    b8.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({b8.out_valid, b8.busy} !== 2'b00)
        $display("FAIL areset_quiet%0d: got %b expected 00", c, {b8.out_valid, b8.busy});
      else passed++;
    end
    b8.out_ready = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [7:0] dv [6];
    int         sels [3] = '{7, 6, 5};
    logic [7:0] ey;
    bit         ee;
    for (int i = 0; i < 6; i++) begin dv[i] = 8'($urandom); b6.d[i] = dv[i]; end
    for (int t = 0; t < 3; t++) begin
      ee = (sels[t] >= 6);
      ey = ee ? 8'h00 : dv[sels[t]];
      b6.mode = 1'b0; b6.sel = 3'(sels[t]); b6.start = 1'b1; b6.out_ready = 1'b0;
      step();
      b6.start = 1'b0;
      total++;
      if ({b6.out_valid, b6.err, b6.done, b6.y_ch, b6.y} !== {1'b1, ee, 1'b0, 3'(sels[t]), ey})
        $display("FAIL oob_capture sel%0d: got %h expected %h", sels[t],
                 {b6.out_valid, b6.err, b6.done, b6.y_ch, b6.y}, {1'b1, ee, 1'b0, 3'(sels[t]), ey});
      else passed++;
      b6.out_ready = 1'b1;
      step();
      total++;
      if ({b6.out_valid, b6.err, b6.done, b6.busy} !== 4'b0010)
        $display("FAIL oob_done sel%0d: got %b expected 0010", sels[t], {b6.out_valid, b6.err, b6.done, b6.busy});
      else passed++;
      b6.out_ready = 1'b0;
      step();
    end
  endtask

  task automatic test_nch1;
    logic [7:0] dv;
    dv = 8'($urandom);
    b1.d[0] = dv; b1.mode = 1'b1; b1.sel = 1'b1; b1.start = 1'b1; b1.out_ready = 1'b1;
    step();
    b1.start = 1'b0;
    total++;
    if ({b1.out_valid, b1.err, b1.y_ch, b1.y} !== {2'b10, 1'b0, dv})
      $display("FAIL nch1_sample: got %h expected %h", {b1.out_valid, b1.err, b1.y_ch, b1.y}, {2'b10, 1'b0, dv});
    else passed++;
    step();
    total++;
    if ({b1.out_valid, b1.busy, b1.done} !== 3'b001)
      $display("FAIL nch1_done: got %b expected 001", {b1.out_valid, b1.busy, b1.done});
    else passed++;
    b1.mode = 1'b0; b1.sel = 1'b1; b1.start = 1'b1; b1.out_ready = 1'b0;
    step();
    b1.start = 1'b0;
    total++;
    if ({b1.out_valid, b1.err, b1.y} !== {2'b11, 8'h00})
      $display("FAIL nch1_oob: got %h expected %h", {b1.out_valid, b1.err, b1.y}, {2'b11, 8'h00});
    else passed++;
    b1.out_ready = 1'b1;
    step();
    b1.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan(0);
    test_scan(1);
    test_scan(2);
    test_scan(2);
    test_abort();
    test_async_reset();
    test_out_of_range();
    test_nch1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
